stepdiff_seq: RTL and testbench

Move sequencer for the two-wheel differential stepper drive. Accepts one move command at a time over a valid/ready handshake, containing a per-wheel step count, speed code and direction. Drives both wheels' 4-phase coil patterns with a stepwise speed ramp, and signals completion. All stepping is derived from single-cycle step enables in the clk domain; there are no generated clocks.

---
 rtl/stepdiff_pkg.sv | 37 +++
 rtl/stepdiff_axis.sv | 102 ++++++++++
 rtl/stepdiff_seq.sv | 115 +++++++++++
 tb/tb_stepdiff_seq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stepdiff_pkg.sv
// Shared definitions for the differential stepper move sequencer.
//   - speed table (Hz per level) and the step-period helper
//   - left/right 4-phase coil pattern tables and the pattern lookup helper
//   - sequencer state encoding
package stepdiff_pkg;

  localparam int unsigned SPD_HZ_0 = 60;
  localparam int unsigned SPD_HZ_1 = 120;
  localparam int unsigned SPD_HZ_2 = 240;
  localparam int unsigned SPD_HZ_3 = 400;

  // Coil order is {A, B, /A, /B}; tables are in forward-direction order.
  localparam logic [3:0] PAT_L [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
  localparam logic [3:0] PAT_R [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  typedef enum logic {StIdle, StRun} state_e;

  // Step period in clock cycles for a speed level (integer, truncated).
  function automatic int unsigned period_cycles(input int unsigned clk_hz,
                                                input logic [1:0] lvl);
    case (lvl)
      2'd0:    return clk_hz / SPD_HZ_0;
      2'd1:    return clk_hz / SPD_HZ_1;
      2'd2:    return clk_hz / SPD_HZ_2;
      default: return clk_hz / SPD_HZ_3;
    endcase
  endfunction

  // Reverse direction walks the table backwards: index 3-ph == ~ph for 2 bits.
  function automatic logic [3:0] coil_pattern(input logic mirror, input logic dir,
                                              input logic [1:0] ph);
    logic [1:0] idx;
    idx = dir ? ~ph : ph;
    return mirror ? PAT_R[idx] : PAT_L[idx];
  endfunction

endpackage

// File: rtl/stepdiff_axis.sv
// One wheel axis: period counter, remaining/done step counters, ramp level,
// phase index and coil pattern register.
//   clk, rst        clock, synchronous active-high reset
//   load            accept pulse: latch steps/target/dir, restart at level 0
//   stop            abort: drop all remaining steps, no further pulses
//   dir, target     direction and target speed level
//   steps           step count for this move
//   step            one-cycle pulse per step
//   finished        no steps remaining
//   coil            current coil pattern {A, B, /A, /B}
module stepdiff_axis
  import stepdiff_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 12000000,
  parameter int unsigned RAMP_LOG2 = 4,
  parameter bit          MIRROR    = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        stop,
  input  logic        dir,
  input  logic [1:0]  target,
  input  logic [15:0] steps,
  output logic        step,
  output logic        finished,
  output logic [3:0]  coil
);

  localparam int unsigned PMAX = period_cycles(CLK_HZ, 2'd0);
  localparam int unsigned CW   = $clog2(PMAX + 1);
  localparam logic [CW-1:0] PER [4] = '{
    CW'(period_cycles(CLK_HZ, 2'd0)), CW'(period_cycles(CLK_HZ, 2'd1)),
    CW'(period_cycles(CLK_HZ, 2'd2)), CW'(period_cycles(CLK_HZ, 2'd3))
  };

  logic [CW-1:0] cnt_q;
  logic [15:0]   rem_q, k_q;
  logic [1:0]    lvl_q, tgt_q, ph_q;
  logic          dir_q, step_q;
  logic [3:0]    coil_q;

  logic          fire;
  logic [15:0]   k_next, r_next, ramp_k, ramp_r;
  logic [1:0]    lvl_next;

  // cnt_q counts cycles since the last step (the accept cycle counts as a
  // step at 0), so a pulse lands exactly PER[lvl] cycles after the previous.
  always_comb begin
    fire     = (cnt_q == (PER[lvl_q] - CW'(1)));
    k_next   = k_q + 16'd1;
    r_next   = rem_q - 16'd1;
    ramp_k   = k_next >> RAMP_LOG2;
    ramp_r   = r_next >> RAMP_LOG2;
    lvl_next = tgt_q;
    if (ramp_k < 16'(lvl_next)) lvl_next = ramp_k[1:0];
    if (ramp_r < 16'(lvl_next)) lvl_next = ramp_r[1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      k_q    <= '0;
      lvl_q  <= '0;
      tgt_q  <= '0;
      ph_q   <= '0;
      dir_q  <= 1'b0;
      step_q <= 1'b0;
      coil_q <= '0;
    end else begin
      step_q <= 1'b0;
      if (load) begin
        rem_q <= steps;
        k_q   <= '0;
        lvl_q <= '0;
        tgt_q <= target;
        dir_q <= dir;
        cnt_q <= CW'(1);
      end else if (stop) begin
        rem_q <= '0;
      end else if (rem_q != '0) begin
        if (fire) begin
          step_q <= 1'b1;
          rem_q  <= r_next;
          k_q    <= k_next;
          lvl_q  <= lvl_next;
          cnt_q  <= '0;
          coil_q <= coil_pattern(MIRROR, dir_q, ph_q);
          ph_q   <= ph_q + 2'd1;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  assign step     = step_q;
  assign finished = (rem_q == '0);
  assign coil     = coil_q;

endmodule

// File: rtl/stepdiff_seq.sv
// Two-wheel differential stepper move sequencer.
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid / cmd_ready     move command handshake
//   cmd_dir                   0 forward, 1 reverse (both wheels)
//   cmd_spd_l / cmd_spd_r     target speed codes
//   cmd_steps_l / cmd_steps_r step counts
//   abort                     stop the current move immediately
//   busy                      move in progress
//   done                      one-cycle pulse on normal completion
//   step_l / step_r           one-cycle pulse per wheel step
//   motor_l / motor_r         coil drive {A, B, /A, /B}
module stepdiff_seq
  import stepdiff_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 12000000,
  parameter int unsigned RAMP_LOG2   = 4,
  parameter bit          HOLD_TORQUE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_dir,
  input  logic [1:0]  cmd_spd_l,
  input  logic [1:0]  cmd_spd_r,
  input  logic [15:0] cmd_steps_l,
  input  logic [15:0] cmd_steps_r,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        step_l,
  output logic        step_r,
  output logic [3:0]  motor_l,
  output logic [3:0]  motor_r
);

  state_e     state_q;
  logic       done_q;
  logic       accept, both_zero, stop, fin_l, fin_r;
  logic [3:0] coil_l, coil_r;

  assign cmd_ready = (state_q == StIdle) & ~abort;
  assign accept    = cmd_valid & cmd_ready;
  assign both_zero = (cmd_steps_l == 16'd0) && (cmd_steps_r == 16'd0);
  assign stop      = abort & (state_q == StRun);

  stepdiff_axis #(
    .CLK_HZ    (CLK_HZ),
    .RAMP_LOG2 (RAMP_LOG2),
    .MIRROR    (1'b0)
  ) u_axis_l (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .stop     (stop),
    .dir      (cmd_dir),
    .target   (cmd_spd_l),
    .steps    (cmd_steps_l),
    .step     (step_l),
    .finished (fin_l),
    .coil     (coil_l)
  );

  stepdiff_axis #(
    .CLK_HZ    (CLK_HZ),
    .RAMP_LOG2 (RAMP_LOG2),
    .MIRROR    (1'b1)
  ) u_axis_r (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .stop     (stop),
    .dir      (cmd_dir),
    .target   (cmd_spd_r),
    .steps    (cmd_steps_r),
    .step     (step_r),
    .finished (fin_r),
    .coil     (coil_r)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            // An empty move completes immediately without ever going busy.
            if (both_zero) done_q  <= 1'b1;
            else           state_q <= StRun;
          end
        end
        StRun: begin
          if (abort) begin
            state_q <= StIdle;
          end else if (fin_l && fin_r) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = (state_q == StRun);
  assign done = done_q;

  // Without holding torque the coils are released as soon as the move ends.
  assign motor_l = (HOLD_TORQUE || busy) ? coil_l : 4'b0000;
  assign motor_r = (HOLD_TORQUE || busy) ? coil_r : 4'b0000;

endmodule

// File: tb/tb_stepdiff_seq.sv
// Randomized self-checking bench for stepdiff_seq. Two instances share all
// stimulus: one holds torque after a move, the other releases the coils.
module tb_stepdiff_seq;

  localparam int unsigned CLK_HZ = 24000;
  localparam int unsigned RAMP   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_dir = 1'b0, abort = 1'b0;
  logic [1:0]  cmd_spd_l = '0, cmd_spd_r = '0;
  logic [15:0] cmd_steps_l = '0, cmd_steps_r = '0;

  logic       ready_h, busy_h, done_h, stl_h, str_h;
  logic [3:0] mot_l_h, mot_r_h;
  logic       ready_f, busy_f, done_f, stl_f, str_f;
  logic [3:0] mot_l_f, mot_r_f;

  stepdiff_seq #(.CLK_HZ(CLK_HZ), .RAMP_LOG2(RAMP), .HOLD_TORQUE(1'b1)) u_dut_hold (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(ready_h), .cmd_dir(cmd_dir),
    .cmd_spd_l(cmd_spd_l), .cmd_spd_r(cmd_spd_r), .cmd_steps_l(cmd_steps_l),
    .cmd_steps_r(cmd_steps_r), .abort(abort), .busy(busy_h), .done(done_h),
    .step_l(stl_h), .step_r(str_h), .motor_l(mot_l_h), .motor_r(mot_r_h)
  );

  stepdiff_seq #(.CLK_HZ(CLK_HZ), .RAMP_LOG2(RAMP), .HOLD_TORQUE(1'b0)) u_dut_free (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(ready_f), .cmd_dir(cmd_dir),
    .cmd_spd_l(cmd_spd_l), .cmd_spd_r(cmd_spd_r), .cmd_steps_l(cmd_steps_l),
    .cmd_steps_r(cmd_steps_r), .abort(abort), .busy(busy_f), .done(done_f),
    .step_l(stl_f), .step_r(str_f), .motor_l(mot_l_f), .motor_r(mot_r_f)
  );

  always #5 clk = ~clk;

  // Reference model state: absolute cycle numbers of pending step pulses,
  // the busy window and the done cycle of the current move.
  int cyc = 0;
  int n_checks = 0, n_err = 0;
  int q_l[$], q_r[$];
  int busy_from = 1, busy_to = 0, done_at = -1, acc_cyc = -1;
  bit accepted = 1'b0, m_dir = 1'b0;
  int ph_l = 0, ph_r = 0;
  logic [3:0] m_mot_l = '0, m_mot_r = '0;

  logic [3:0] lf [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
  logic [3:0] lr [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int per(input int lvl);
    case (lvl)
      0:       return CLK_HZ / 60;
      1:       return CLK_HZ / 120;
      2:       return CLK_HZ / 240;
      default: return CLK_HZ / 400;
    endcase
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Step times of one axis from the ramp rule, starting at level 0.
  task automatic plan(input bit right, input int t0, input int n, input int tgt,
                      output int last);
    int t, lvl;
    t = t0 + per(0);
    last = t0;
    for (int k = 1; k <= n; k++) begin
      if (right) q_r.push_back(t);
      else       q_l.push_back(t);
      last = t;
      lvl = imin(tgt, imin(k >> RAMP, (n - k) >> RAMP));
      t += per(lvl);
    end
  endtask

  function automatic bit m_busy(input int c);
    return (c >= busy_from) && (c <= busy_to);
  endfunction

  // Settle the current cycle's inputs, update the model, then advance one
  // clock and compare every output against the model.
  task automatic tick();
    bit bz, es_l, es_r, eb, ed;
    int last_l, last_r;
    #1;
    bz = m_busy(cyc);
    if (!rst && cyc > 0) begin
      check("ready_hold", ready_h, !bz && !abort);
      check("ready_free", ready_f, !bz && !abort);
    end
    if (rst) begin
      q_l.delete(); q_r.delete();
      busy_from = 1; busy_to = 0; done_at = -1;
      ph_l = 0; ph_r = 0; m_mot_l = '0; m_mot_r = '0;
    end else if (abort && bz) begin
      busy_to = cyc;
      done_at = -1;
      while (q_l.size() > 0 && q_l[$] > cyc) void'(q_l.pop_back());
      while (q_r.size() > 0 && q_r[$] > cyc) void'(q_r.pop_back());
    end else if (cmd_valid && !abort && !bz) begin
      accepted = 1'b1;
      acc_cyc  = cyc;
      m_dir    = cmd_dir;
      plan(1'b0, cyc, int'(cmd_steps_l), int'(cmd_spd_l), last_l);
      plan(1'b1, cyc, int'(cmd_steps_r), int'(cmd_spd_r), last_r);
      if (cmd_steps_l == 0 && cmd_steps_r == 0) begin
        done_at = cyc + 1;
      end else begin
        busy_from = cyc + 1;
        busy_to   = (last_l > last_r) ? last_l : last_r;
        done_at   = busy_to + 1;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    es_l = (q_l.size() > 0) && (q_l[0] == cyc);
    es_r = (q_r.size() > 0) && (q_r[0] == cyc);
    if (es_l) begin
      void'(q_l.pop_front());
      m_mot_l = m_dir ? lr[ph_l] : lf[ph_l];
      ph_l = (ph_l + 1) % 4;
    end
    if (es_r) begin
      void'(q_r.pop_front());
      m_mot_r = m_dir ? lf[ph_r] : lr[ph_r];
      ph_r = (ph_r + 1) % 4;
    end
    eb = m_busy(cyc);
    ed = (cyc == done_at);
    check("busy_hold", busy_h, eb);
    check("busy_free", busy_f, eb);
    check("done_hold", done_h, ed);
    check("done_free", done_f, ed);
    check("step_l", stl_h, es_l);
    check("step_r", str_h, es_r);
    check("step_l_free", stl_f, es_l);
    check("step_r_free", str_f, es_r);
    check("motor_l", mot_l_h, m_mot_l);
    check("motor_r", mot_r_h, m_mot_r);
    check("motor_l_free", mot_l_f, eb ? m_mot_l : 4'b0000);
    check("motor_r_free", mot_r_f, eb ? m_mot_r : 4'b0000);
  endtask

  task automatic issue(input int dir, input int nl, input int sl, input int nr, input int sr);
    int i;
    cmd_dir     = dir[0];
    cmd_steps_l = 16'(nl);
    cmd_spd_l   = 2'(sl);
    cmd_steps_r = 16'(nr);
    cmd_spd_r   = 2'(sr);
    cmd_valid   = 1'b1;
    accepted    = 1'b0;
    i = 0;
    while (!accepted && i < 20000) begin
      tick();
      i++;
    end
    cmd_valid = 1'b0;
    if (!accepted) check("accept_wait", 32'(i), 32'(i + 1));
  endtask

  task automatic run_idle(input int max);
    int i;
    i = 0;
    while ((cyc <= busy_to || cyc <= done_at || q_l.size() > 0 || q_r.size() > 0)
           && i < max) begin
      tick();
      i++;
    end
    if (i >= max) check("idle_wait", 32'(i), 32'(max + 1));
    repeat (3) tick();
  endtask

  initial begin
    int t0, n;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    issue(0, 4, 0, 0, 0);
    run_idle(4000);
    issue(0, 16, 3, 0, 0);
    run_idle(8000);
    issue(1, 4, 1, 4, 0);
    run_idle(4000);

    // Abort mid-move with the next command already waiting.
    issue(0, 100, 3, 100, 3);
    t0 = acc_cyc;
    cmd_dir = 1'b0; cmd_steps_l = 16'd3; cmd_spd_l = 2'd2;
    cmd_steps_r = 16'd5; cmd_spd_r = 2'd1;
    cmd_valid = 1'b1;
    while (cyc < t0 + 1000) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    cmd_valid = 1'b0;
    run_idle(6000);

    issue(0, 0, 0, 0, 0);
    run_idle(100);

    // Reset in the middle of a move.
    issue(1, 10, 2, 7, 3);
    repeat (300) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run_idle(100);

    repeat (8) begin
      issue($urandom_range(1, 0), $urandom_range(12, 0), $urandom_range(3, 0),
            $urandom_range(12, 0), $urandom_range(3, 0));
      if ($urandom_range(2, 0) == 0) begin
        n = $urandom_range(2500, 1);
        for (int i = 0; i < n && m_busy(cyc); i++) tick();
        if (m_busy(cyc)) begin
          abort = 1'b1;
          tick();
          abort = 1'b0;
        end
      end
      run_idle(8000);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
